// File: rtl/reg_bank_scan.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_scan
// Purpose  : Four-entry operand register bank feeding a 4-to-1 byte mux.
//            Drives the mux data inputs (r1..r4) and its selects (s1,s0).
//            Registers are written over a valid/ready port. The select
//            either follows a registered manual select (IDLE) or steps
//            through all four inputs in Gray order 00,10,11,01 ({s1,s0}),
//            holding each value for HOLD cycles (SCAN), then pulses
//            scan_done for one cycle (DONE).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            wr_valid/wr_ready - write handshake; wr_addr/wr_data target
//            sel_manual        - select {s1,s0} used while idle
//            scan_start        - begin a scan (sampled in IDLE only)
//            scan_busy         - high for exactly 4*HOLD cycles per scan
//            scan_done         - one-cycle completion pulse
//            r1..r4, s0, s1    - registered mux data and select outputs
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_scan #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4     // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       sel_manual,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_done,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic             s0,
    output logic             s1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // HOLD never exceeds 255, so an 8-bit hold counter always suffices.
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD - 1);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [1:0]       r_sel;       // {s1,s0}
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_bank [4];

    state_t           w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_ready_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_wr_fire;

    // wr_ready is registered, so a write coincident with scan_start in IDLE
    // is still accepted and lands before the first scan cycle.
    assign w_wr_fire = wr_valid && r_ready;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sel_nxt   = sel_manual;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                if (scan_start) begin
                    w_state_nxt = ST_SCAN;
                    w_sel_nxt   = 2'b00;
                    w_cnt_nxt   = 8'd0;
                    w_busy_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                end
            end

            ST_SCAN: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt_nxt = 8'd0;
                    // Gray walk 00 -> 10 -> 11 -> 01; leaving 01 ends the scan
                    // with the select parked on 01 for the DONE cycle.
                    case (r_sel)
                        2'b00: w_sel_nxt = 2'b10;
                        2'b10: w_sel_nxt = 2'b11;
                        2'b11: w_sel_nxt = 2'b01;
                        default: begin
                            w_sel_nxt   = 2'b01;
                            w_state_nxt = ST_DONE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_sel_nxt   = sel_manual;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_sel   <= 2'b00;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_wr_fire) begin
                r_bank[wr_addr] <= wr_data;
            end
        end
    end

    assign wr_ready  = r_ready;
    assign scan_busy = r_busy;
    assign scan_done = r_done;
    assign s1        = r_sel[1];
    assign s0        = r_sel[0];
    assign r1        = r_bank[0];
    assign r2        = r_bank[1];
    assign r3        = r_bank[2];
    assign r4        = r_bank[3];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_scan
// Purpose  : Self-checking bench for reg_bank_scan. A HOLD=4 instance runs
//            the load/select vector table and the scan sequences; a HOLD=1
//            instance checks the minimum-hold scan length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic [1:0] sel_manual = 2'd0;
    logic       scan_start = 1'b0;
    logic       scan_start1 = 1'b0;

    logic       wr_ready, scan_busy, scan_done, s0, s1;
    logic [7:0] r1, r2, r3, r4;
    logic       d1_ready, d1_busy, d1_done, d1_s0, d1_s1;
    logic [7:0] d1_r1, d1_r2, d1_r3, d1_r4;

    int errors = 0;
    int checks = 0;
    int done_pulses;

    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    reg_bank_scan #(.WIDTH(8), .HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .sel_manual(sel_manual), .scan_start(scan_start),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .s0(s0), .s1(s1)
    );

    reg_bank_scan #(.WIDTH(8), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(d1_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .sel_manual(sel_manual), .scan_start(scan_start1),
        .scan_busy(d1_busy), .scan_done(d1_done),
        .r1(d1_r1), .r2(d1_r2), .r3(d1_r3), .r4(d1_r4),
        .s0(d1_s0), .s1(d1_s1)
    );

    typedef struct {
        logic        wv;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [1:0]  sm;
        logic [31:0] exp_regs;   // {r1,r2,r3,r4}
        logic [1:0]  exp_sel;    // {s1,s0}
        logic [7:0]  exp_mux;
    } vec_t;

    vec_t vecs [10];

    // Downstream 4-to-1 mux as seen by the consumer of the bank.
    function automatic logic [7:0] mux4(input logic [1:0] sel);
        case (sel)
            2'd0:    return r1;
            2'd1:    return r2;
            2'd2:    return r3;
            default: return r4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (scan_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", {31'd0, scan_done}, 32'd1);
    endtask

    always @(posedge clk) begin
        if (scan_done === 1'b1) done_pulses <= done_pulses + 1;
    end

    initial begin
        vecs[0] = '{1'b1, 2'd0, 8'h00, 2'd0, 32'h00000000, 2'd0, 8'h00};
        vecs[1] = '{1'b1, 2'd1, 8'hAA, 2'd0, 32'h00AA0000, 2'd0, 8'h00};
        vecs[2] = '{1'b1, 2'd2, 8'hFF, 2'd0, 32'h00AAFF00, 2'd0, 8'h00};
        vecs[3] = '{1'b1, 2'd3, 8'h55, 2'd0, 32'h00AAFF55, 2'd0, 8'h00};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 2'd2, 32'h00AAFF55, 2'd2, 8'hFF};
        vecs[5] = '{1'b0, 2'd0, 8'h00, 2'd0, 32'h00AAFF55, 2'd0, 8'h00};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 2'd1, 32'h00AAFF55, 2'd1, 8'hAA};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd3, 32'h00AAFF55, 2'd3, 8'h55};
        vecs[8] = '{1'b1, 2'd0, 8'h12, 2'd0, 32'h12AAFF55, 2'd0, 8'h12};
        vecs[9] = '{1'b1, 2'd0, 8'h00, 2'd0, 32'h00AAFF55, 2'd0, 8'h00};
        done_pulses = 0;

        // ---- reset state ----
        rst = 1'b1;
        step();
        step();
        check("reset_regs", {r1, r2, r3, r4}, 32'h0);
        check("reset_sel", {30'd0, s1, s0}, 32'd0);
        check("reset_flags", {29'd0, wr_ready, scan_busy, scan_done}, 32'b100);
        rst = 1'b0;

        // ---- load and manual select table ----
        for (int i = 0; i < 10; i++) begin
            wr_valid   = vecs[i].wv;
            wr_addr    = vecs[i].addr;
            wr_data    = vecs[i].data;
            sel_manual = vecs[i].sm;
            step();
            check($sformatf("vec%0d_regs", i), {r1, r2, r3, r4}, vecs[i].exp_regs);
            check($sformatf("vec%0d_sel", i), {30'd0, s1, s0}, {30'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_mux", i), {24'd0, mux4({s1, s0})}, {24'd0, vecs[i].exp_mux});
            check($sformatf("vec%0d_ready", i), {31'd0, wr_ready}, 32'd1);
        end
        wr_valid = 1'b0;

        // ---- HOLD=4 scan with a blocked write to r2 ----
        done_pulses = 0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 8'h3C;
        sel_manual = 2'd2;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("scan_c%0d", c), {27'd0, s1, s0, scan_busy, wr_ready, scan_done},
                  {27'd0, gray[c / 4], 1'b1, 1'b0, 1'b0});
            step();
        end
        check("scan_done_state", {27'd0, s1, s0, scan_busy, wr_ready, scan_done}, {27'd0, 2'b01, 3'b001});
        check("scan_r2_frozen", {24'd0, r2}, 32'h000000AA);
        step();
        check("after_done_idle", {27'd0, s1, s0, scan_busy, wr_ready, scan_done}, {27'd0, 2'b10, 3'b010});
        check("r2_still_frozen", {24'd0, r2}, 32'h000000AA);
        step();
        check("r2_reissued", {24'd0, r2}, 32'h0000003C);
        check("done_pulse_count", done_pulses, 32'd1);
        wr_valid = 1'b0;
        sel_manual = 2'd0;

        // ---- simultaneous write + scan_start, then reset in the 11 phase ----
        wr_valid   = 1'b1;
        wr_addr    = 2'd0;
        wr_data    = 8'h77;
        scan_start = 1'b1;
        step();
        wr_valid   = 1'b0;
        scan_start = 1'b0;
        check("simul_first_cycle", {21'd0, r1, s1, s0, scan_busy},
              {21'd0, 8'h77, 2'b00, 1'b1});
        for (int c = 0; c < 8; c++) step();
        check("in_phase_11", {30'd0, s1, s0}, 32'd3);
        done_pulses = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midscan_rst_regs", {r1, r2, r3, r4}, 32'h0);
        check("midscan_rst_flags", {27'd0, s1, s0, scan_busy, wr_ready, scan_done}, {27'd0, 2'b00, 3'b010});
        for (int c = 0; c < 20; c++) step();
        check("midscan_no_done", done_pulses, 32'd0);

        // ---- scan_start held high: one idle cycle between scans ----
        scan_start = 1'b1;
        step();
        check("held_first_busy", {31'd0, scan_busy}, 32'd1);
        wait_done(40);
        step();
        check("held_gap_idle", {29'd0, scan_busy, wr_ready, scan_done}, 32'b010);
        step();
        check("held_restart", {29'd0, scan_busy, wr_ready, s1, s0}, {29'd0, 1'b1, 1'b0, 2'b00} >> 0);
        scan_start = 1'b0;
        wait_done(40);
        step();

        // ---- HOLD=1 instance: select changes every cycle, busy for 4 ----
        scan_start1 = 1'b1;
        step();
        scan_start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("hold1_c%0d", c), {28'd0, d1_s1, d1_s0, d1_busy, d1_done},
                  {28'd0, gray[c], 1'b1, 1'b0});
            step();
        end
        check("hold1_done", {28'd0, d1_s1, d1_s0, d1_busy, d1_done}, {28'd0, 2'b01, 2'b01});
        step();
        check("hold1_idle", {29'd0, d1_busy, d1_ready, d1_done}, 32'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
